relu_maxpool_2x2: RTL
=====================

Name: relu_maxpool_2x2

Overview:
- Downstream neighbour of the 3x3 convolution stage.
- Consumes the raster-order stream of signed 18-bit convolution results.
- Applies ReLU, requantises each value to unsigned 8-bit with a right shift and saturation, then performs 2x2 max-pooling with stride 2.
- Emits the pooled 8-bit stream with a valid strobe and an end-of-frame pulse, ready for the next conv layer's 8-bit input.

Parameters:
- DIN_W, 18, input sample width (signed).
- DOUT_W, 8, output sample width (unsigned).
- IN_W, 478, input columns per row (conv output width).
- IN_H, 270, input rows per frame.
- SHIFT, 0, arithmetic right shift applied after ReLU before saturation.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  din carries a valid sample this cycle.
- din  input  DIN_W  signed conv result, raster order.
- valid_out  output  1  dout valid; one-cycle strobe per pooled pixel.
- dout  output  DOUT_W  unsigned pooled value.
- frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Behaviour:
- Reset values: valid_out=0, dout=0, frame_done=0, col=0, row=0, all pipeline valids=0. Line-buffer contents are not reset; they are always written before being read.
- Stage 1 (registered), on valid_in: q = (din<0) ? 0 : (din>>>SHIFT). If q > 2^DOUT_W-1, q = 2^DOUT_W-1. Width rule: shift is done at DIN_W and compared before truncation.
- Counters col (0..IN_W-1) and row (0..IN_H-1) advance only on a stage-1 valid sample. col wraps to 0 and increments row. At the last pixel both wrap to 0, so the next frame starts with no idle cycle required.
- Horizontal pair:
  - Even col: latch q into h_reg.
  - Odd col: hmax = max(h_reg, q), unsigned compare.
- Even row: write hmax to the line buffer at address col>>1 on the odd-col sample.
- Odd row:
  - On the even-col sample, issue a synchronous read of address col>>1. The read data register holds its value until the next read.
  - On the odd-col sample, dout = max(rdata, hmax), registered, and valid_out=1.
- Latency: 2 clk from the valid_in of input pixel (2r+1, 2c+1) to valid_out.
- Output count per frame: floor(IN_W/2) x floor(IN_H/2).
  - Odd IN_W: the last column of every row is consumed by the counters but never pooled.
  - Odd IN_H: the last row is consumed but produces no output.
- valid_in gaps of any length: the pipeline and counters hold, with no output and no corruption. Back-to-back valid_in must be sustained at 1 sample/clk.
- frame_done=1 in the same cycle as valid_out for pooled pixel (floor(IN_H/2)-1, floor(IN_W/2)-1).
- Line buffer read/write conflict is impossible: writes occur only on even rows, reads only on odd rows.
- rst mid-frame: all counters and valids clear on the next edge. Partially pooled data is discarded, and the next valid_in is treated as pixel (0,0).
- No backpressure; the downstream stage must accept every valid_out.

Decomposition:
- Shared package: DIN_W, DOUT_W and the default IN_W/IN_H frame-size constants used by the conv and pool stages, plus a saturating ReLU-requantise function reused by later layers.
- One sub-module: pool_line_buffer. It is a simple-dual-port RAM of depth IN_W/2 x DOUT_W with one write port, one synchronous read port, and a registered read output. It must be inferable as block RAM.

Test Plan:
- Reset (IN_W=4, IN_H=4, SHIFT=0): hold rst=1 for 5 clk with random din/valid_in → valid_out=0, dout=0, frame_done=0 throughout.
- Basic pool (IN_W=4, IN_H=4, SHIFT=0): feed din=1..16 row-major, continuous valid → dout sequence 6, 8, 14, 16. Each valid_out arrives 2 clk after din=6, 8, 14, 16 respectively; frame_done only with the 16.
- ReLU/saturation (SHIFT=2, all four pixels of each window equal):
  - window value -5 → 0
  - window value 1000 → 250
  - window value 2000 → 255
  - window value -131072 → 0
- Stall tolerance: repeat the basic pool with valid_in toggling 1,0,0,1,… (pseudo-random gaps) → identical outputs 6, 8, 14, 16 and exactly 4 valid_out pulses.
- Odd dimensions (IN_W=5, IN_H=5): feed din=1..25 → outputs 7, 9, 17, 19 only; column 5 and row 5 are ignored; frame_done with 19. A second back-to-back frame of the same data gives an identical result.
- Mid-frame reset (IN_W=4, IN_H=4): send 6 samples, pulse rst for 1 clk, then a full 1..16 frame → exactly 4 outputs 6, 8, 14, 16, with no stale value from the aborted frame.

Source files
------------

// File: rtl/relu_maxpool_2x2_pkg.sv
// relu_maxpool_2x2_pkg: shared widths, frame-size defaults and requantise helpers for the conv/pool chain.
package relu_maxpool_2x2_pkg;

    localparam int DIN_W    = 18;
    localparam int DOUT_W   = 8;
    localparam int IN_W_DEF = 478;
    localparam int IN_H_DEF = 270;

    localparam logic signed [DIN_W-1:0] SAT_MAX = DIN_W'((1 << DOUT_W) - 1);

    // Shift happens at full input width; saturation is decided before truncating to DOUT_W.
    function automatic logic [DOUT_W-1:0] relu_requant(input logic signed [DIN_W-1:0] x, input int sh);
        logic signed [DIN_W-1:0] s;
        s = x >>> sh;
        return x[DIN_W-1] ? '0 : (s > SAT_MAX) ? '1 : s[DOUT_W-1:0];
    endfunction

    function automatic logic [DOUT_W-1:0] umax(input logic [DOUT_W-1:0] a, input logic [DOUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// relu_maxpool_2x2_if: conv-result input stream and pooled 8-bit output stream of the pool stage.
interface relu_maxpool_2x2_if;
    import relu_maxpool_2x2_pkg::*;

    logic                     valid_in;
    logic signed [DIN_W-1:0]  din;
    logic                     valid_out;
    logic        [DOUT_W-1:0] dout;
    logic                     frame_done;

    modport master (output valid_in, din, input valid_out, dout, frame_done);
    modport slave  (input valid_in, din, output valid_out, dout, frame_done);

endinterface

// File: rtl/relu_maxpool_2x2_pool_line_buffer.sv
// relu_maxpool_2x2_pool_line_buffer: simple dual-port RAM holding one row of horizontal maxima, registered read.
module relu_maxpool_2x2_pool_line_buffer #(
    parameter int DEPTH = 239,
    parameter int W     = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU + shift/saturate requantisation followed by 2x2 stride-2 max-pooling of a raster stream.
module relu_maxpool_2x2
    import relu_maxpool_2x2_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int IN_H  = IN_H_DEF,
    parameter int SHIFT = 0
) (
    input logic               clk,
    input logic               rst,
    relu_maxpool_2x2_if.slave pool_io
);
    localparam int CW    = $clog2(IN_W + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int DEPTH = (IN_W / 2 > 0) ? IN_W / 2 : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COL_MAX       = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_MAX       = RW'(IN_H - 1);
    localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * (IN_W / 2) - 1);
    localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * (IN_H / 2) - 1);

    logic              s1_valid_q;
    logic [DOUT_W-1:0] s1_pix_q;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DOUT_W-1:0] h_q, hmax, rdata;
    logic              wr_en, rd_en, pool_fire, last_pool;
    logic [AW-1:0]     lb_addr;
    logic              valid_out_q, frame_done_q;
    logic [DOUT_W-1:0] dout_q;

    // Counters describe the stage-1 sample, so every decision below refers to s1_pix_q.
    always_comb begin
        col_d     = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
        row_d     = (col_q != COL_MAX) ? row_q : (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        hmax      = umax(h_q, s1_pix_q);
        wr_en     = s1_valid_q & ~row_q[0] & col_q[0];
        rd_en     = s1_valid_q & row_q[0] & ~col_q[0];
        pool_fire = s1_valid_q & row_q[0] & col_q[0];
        last_pool = (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
        lb_addr   = AW'(col_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            s1_valid_q   <= pool_io.valid_in;
            if (pool_io.valid_in) s1_pix_q <= relu_requant(pool_io.din, SHIFT);
            valid_out_q  <= pool_fire;
            frame_done_q <= pool_fire & last_pool;
            if (pool_fire) dout_q <= umax(rdata, hmax);
            if (s1_valid_q) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q & ~col_q[0]) h_q <= s1_pix_q;
    end

    relu_maxpool_2x2_pool_line_buffer #(
        .DEPTH (DEPTH),
        .W     (DOUT_W),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .re_i    (rd_en),
        .raddr_i (lb_addr),
        .rdata_o (rdata)
    );

    assign pool_io.valid_out  = valid_out_q;
    assign pool_io.dout       = dout_q;
    assign pool_io.frame_done = frame_done_q;

endmodule
